// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold until release.
// Optional forced revocation of long-held grants when ARB_TIMEOUT_EN is defined.
module rr_arbiter4 #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] pick;
  logic       release_now;
  logic       tmo_fire;

  // First set bit at or after p, wrapping modulo 4; descending scan lets the
  // nearest candidate overwrite the farther ones.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign pick        = rr_pick(req, ptr);
  assign release_now = done | ~req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  assign tmo_fire = (hold_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero in IDLE, so it is cleared on every entry to GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      timeout <= (state == GRANT) && !release_now && tmo_fire;
      if (state == IDLE)
        hold_cnt <= 8'd0;
      else if (!release_now && !tmo_fire)
        hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (|req) begin
        gnt       <= 4'b0001 << pick;
        gnt_idx   <= pick;
        gnt_valid <= 1'b1;
        state     <= GRANT;
      end
    end else begin
      // Normal release and timeout revocation leave identical state behind.
      if (release_now || tmo_fire) begin
        gnt       <= 4'b0000;
        gnt_valid <= 1'b0;
        ptr       <= gnt_idx + 2'd1;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares a single downstream resource (bus, encoder datapath, memory port) among four requesters. It resolves a 4-bit request vector to a one-hot grant plus a 2-bit encoded grant index using a rotating-priority encoder. It holds the grant until the owner releases the resource. It sits between the requesting blocks and the shared datapath, and drives the datapath's select input with `gnt_idx`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum cycles one grant may be held. Used only when `ARB_TIMEOUT_EN` is defined. Legal range is 2..255.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  4  request vector; bit i = requester i wants the resource. Level-sensitive.
- `done`  input  1  the current owner releases the resource this cycle.
- `gnt`  output  4  one-hot grant, registered; all zeros when idle.
- `gnt_idx`  output  2  binary index of the granted requester, registered; holds its last value when idle.
- `gnt_valid`  output  1  high while any grant is active; equals `|gnt`.
- `timeout`  output  1  one-cycle pulse when a grant is forcibly revoked. Constant 0 without `ARB_TIMEOUT_EN`.

## Operation
- Single clock domain: `clk`.
- `rst_n` is asynchronous and active-low.
- State machine has two states: IDLE and GRANT.
- Internal 2-bit priority pointer `ptr` names the highest-priority requester.
- Reset values:
  - state = IDLE, `ptr` = 0
  - `gnt` = 4'b0000, `gnt_idx` = 2'b00, `gnt_valid` = 0, `timeout` = 0
  - hold counter = 0
- IDLE:
  - If `req` = 0, stay in IDLE.
  - Otherwise, select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3, with indices taken modulo 4 (3 wraps to 0).
  - Register the selection into `gnt`/`gnt_idx`, set `gnt_valid`, and go to GRANT.
- GRANT release condition: `done` = 1, or `req[gnt_idx]` = 0 (requester dropped its request).
- On release:
  - Clear `gnt` and `gnt_valid`.
  - Set `ptr` to `gnt_idx`+1 mod 4; 3 wraps to 0.
  - Go to IDLE.
- While in GRANT, requests from other requesters are ignored; there is no preemption.
- Simultaneous events:
  - `done` together with new requests: release takes priority. The new requests are arbitrated from IDLE on the following cycle using the updated `ptr`.
  - `done` asserted while in IDLE: ignored.
- Fairness: a continuously requesting requester waits at most 3 grants before being served.
- Reset asserted mid-grant: outputs clear immediately (asynchronously) and `ptr` returns to 0.

## Timing
- Request-to-grant latency: `req` sampled at edge N in IDLE produces `gnt` valid after edge N (one cycle).
- Release-to-clear latency: `done` sampled at edge M produces `gnt` = 0 after edge M.
- A mandatory one-cycle IDLE gap follows every release, so back-to-back grants to different requesters are 2 cycles apart.
- Maximum grant rate is one grant per 2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset deassertion is taken synchronously by the first following clock edge. The first grant can appear no earlier than one edge after `rst_n` rises.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on entry to GRANT and increments every cycle spent in GRANT.
  - If the counter reaches `TIMEOUT_CYCLES`-1 with no release, the grant is revoked on that edge, exactly as a normal release (ptr advances, state goes to IDLE).
  - `timeout` pulses high for exactly one cycle, aligned with `gnt` going to 0.
  - If a normal release and the timeout coincide, the normal release wins and `timeout` stays 0.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built and `timeout` is tied to 0.
  - A grant is held indefinitely until a normal release.

## Test plan
- Reset: hold `rst_n`=0 with `req`=4'b1111 → `gnt`=0000, `gnt_valid`=0, `gnt_idx`=00. First grant after release of reset is `gnt`=0001.
- Rotation: `req`=4'b1111 held, `done` pulsed 1 cycle after each grant → grant order 0,1,2,3,0 (`gnt_idx` 00,01,10,11,00), each grant separated by one idle cycle.
- Skip and wrap: ptr=3 after serving requester 2, `req`=4'b0101 → grant requester 0 (`gnt`=0001), then requester 2 next.
- Hold and drop: grant requester 1, raise `req[0]` while `done`=0 → `gnt` stays 0010. Then deassert `req[1]` → `gnt`=0000 on the next edge, then requester 0 is granted.
- Async reset mid-grant: drop `rst_n` between clock edges while `gnt`=0100 → `gnt`=0000 immediately (before the next edge) and ptr=0.
- Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): grant requester 2, never assert `done` → `gnt` clears 4 cycles after grant with `timeout`=1 for one cycle, then requester 3 is granted if it is requesting.
